// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - MM:SS.hh BCD stopwatch driven by a divided-clock tick treated as data
module stopwatch_core #(
  parameter bit WRAP        = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_clk,
  input  logic        start_stop,
  input  logic        clear,
  output logic        running,
  output logic [23:0] digits,
  output logic        rollover
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  localparam logic [23:0] TERMINAL = 24'h595999;

  logic [SYNC_STAGES-1:0] tick_sync_q, start_sync_q, clear_sync_q;
  logic                   tick_prev_q, start_prev_q, clear_prev_q;
  logic                   tick_rise, start_rise, clear_rise;

  state_t      state_q, state_d;
  logic [23:0] digits_q, digits_d;
  logic        rollover_q, rollover_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_sync_q  <= '0;
      start_sync_q <= '0;
      clear_sync_q <= '0;
      tick_prev_q  <= 1'b0;
      start_prev_q <= 1'b0;
      clear_prev_q <= 1'b0;
    end else begin
      tick_sync_q  <= {tick_sync_q[SYNC_STAGES-2:0], tick_clk};
      start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], start_stop};
      clear_sync_q <= {clear_sync_q[SYNC_STAGES-2:0], clear};
      tick_prev_q  <= tick_sync_q[SYNC_STAGES-1];
      start_prev_q <= start_sync_q[SYNC_STAGES-1];
      clear_prev_q <= clear_sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_rise  = tick_sync_q[SYNC_STAGES-1] & ~tick_prev_q;
  assign start_rise = start_sync_q[SYNC_STAGES-1] & ~start_prev_q;
  assign clear_rise = clear_sync_q[SYNC_STAGES-1] & ~clear_prev_q;

  // Ripple a +1 through the six BCD digits, LSB (hundredths ones) first; tens of seconds and minutes stop at 5.
  function automatic logic [23:0] bcd_inc(input logic [23:0] d);
    logic [23:0] r;
    logic        carry;
    logic [3:0]  lim;
    r     = d;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (carry) begin
        if (d[i*4 +: 4] == lim) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = d[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      digits_q   <= '0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      rollover_q <= rollover_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    rollover_d = 1'b0;
    if (clear_rise) begin
      state_d  = S_IDLE;
      digits_d = '0;
    end else if (start_rise) begin
      state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
    end else if (tick_rise && state_q == S_RUN) begin
      if (digits_q == TERMINAL) begin
        rollover_d = 1'b1;
        if (WRAP) digits_d = '0;
        else      state_d  = S_PAUSE;
      end else begin
        digits_d = bcd_inc(digits_q);
      end
    end
  end

  assign running  = (state_q == S_RUN);
  assign digits   = digits_q;
  assign rollover = rollover_q;

endmodule
